// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop synchronizer, oversampled bit timing with a 3-sample
// majority vote, start/parity/stop checking and a one-entry valid/ready
// holding register with one-cycle status pulses.
`timescale 1ns/1ps
module uart_rx_core #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_en,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_busy,
  output logic                 rx_done,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 rx_overrun
);

  localparam int DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int S_W   = $clog2(OVERSAMPLE);
  localparam int M     = OVERSAMPLE / 2;
  localparam int IDX_W = 4;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic                 rx_meta_q, rx_s_q;
  logic [S_W-1:0]       s_q, s_d;
  logic [IDX_W-1:0]     bidx_q, bidx_d;
  logic [1:0]           smp_q, smp_d;
  logic                 bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_bad_q, par_bad_d;
  logic                 dlv_q, dlv_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_q, perr_d;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q, done_q, ovr_q;

  logic tick, in_frame, bit_mid, bit_end, maj;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Parity bit the transmitter should have sent for this payload.
  function automatic logic exp_parity(input logic [DATA_BITS-1:0] d);
    return (^d) ^ (PARITY_ODD != 0);
  endfunction

  assign tick     = (cnt_q == CNT_W'(DIV - 1));
  assign in_frame = (state_q == S_START) || (state_q == S_DATA) ||
                    (state_q == S_PARITY) || (state_q == S_STOP);
  assign bit_mid  = tick && (s_q == S_W'(M + 1));
  assign bit_end  = tick && (s_q == S_W'(OVERSAMPLE - 1));
  // Third vote is the live synchronized line at s = M+1.
  assign maj      = maj3(smp_q[0], smp_q[1], rx_s_q);

  // Two-flop synchronizer for the asynchronous line, idles high.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Free-running oversample tick divider.
  always_ff @(posedge clk) begin
    if (reset)     cnt_q <= '0;
    else if (tick) cnt_q <= '0;
    else           cnt_q <= cnt_q + 1'b1;
  end

  // Next-state logic: bit timing, majority capture and frame checks.
  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    bidx_d    = bidx_q;
    smp_d     = smp_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    par_bad_d = par_bad_q;
    dlv_d     = 1'b0;
    ferr_d    = 1'b0;
    perr_d    = 1'b0;
    if (tick && in_frame) begin
      s_d = bit_end ? '0 : s_q + 1'b1;
      if (s_q == S_W'(M - 1)) smp_d[0] = rx_s_q;
      if (s_q == S_W'(M))     smp_d[1] = rx_s_q;
    end
    case (state_q)
      S_IDLE: begin
        if (tick && rx_en && !rx_s_q) begin
          state_d   = S_START;
          s_d       = '0;
          par_bad_d = 1'b0;
        end
      end
      S_START: begin
        if (bit_mid && maj) begin
          state_d = S_IDLE;
        end else if (bit_end) begin
          state_d = S_DATA;
          bidx_d  = '0;
        end
      end
      S_DATA: begin
        if (bit_mid) bit_d = maj;
        if (bit_end) begin
          shreg_d = {bit_q, shreg_q[DATA_BITS-1:1]};
          bidx_d  = bidx_q + 1'b1;
          if (bidx_q == IDX_W'(DATA_BITS - 1))
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (bit_mid) par_bad_d = (maj != exp_parity(shreg_q));
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        // Leave half a bit early so the next start edge is not missed.
        if (bit_mid) begin
          if (!maj) begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end else begin
            perr_d  = par_bad_q;
            dlv_d   = !par_bad_q;
            state_d = S_IDLE;
          end
        end
      end
      S_BREAK: begin
        if (tick && rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (!rx_en) begin
      state_d = S_IDLE;
      dlv_d   = 1'b0;
      ferr_d  = 1'b0;
      perr_d  = 1'b0;
    end
  end

  // Receiver state and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      s_q       <= '0;
      bidx_q    <= '0;
      smp_q     <= 2'b11;
      bit_q     <= 1'b0;
      shreg_q   <= '0;
      par_bad_q <= 1'b0;
      dlv_q     <= 1'b0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      bidx_q    <= bidx_d;
      smp_q     <= smp_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      par_bad_q <= par_bad_d;
      dlv_q     <= dlv_d;
      ferr_q    <= ferr_d;
      perr_q    <= perr_d;
    end
  end

  // Holding register: load on a free or simultaneously drained slot, else overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      ovr_q  <= 1'b0;
      if (valid_q && rx_ready) valid_q <= 1'b0;
      if (dlv_q) begin
        if (!valid_q || rx_ready) begin
          data_q  <= shreg_q;
          valid_q <= 1'b1;
          done_q  <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end
    end
  end

  assign data_out   = data_q;
  assign rx_valid   = valid_q;
  assign rx_busy    = in_frame;
  assign rx_done    = done_q;
  assign frame_err  = ferr_q;
  assign parity_err = perr_q;
  assign rx_overrun = ovr_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: a default-rate instance plus two fast instances
// (no parity / even parity) share one serial line; received events are
// scored against an event list built from the frame rules.
`timescale 1ns/1ps
module tb_uart_rx_core;

  localparam int BIT_A  = 864;   // default parameters
  localparam int BIT_F  = 32;    // 3.2 MHz / (100 kbaud * 16) = DIV 2
  localparam int K_DONE = 1;
  localparam int K_FERR = 2;
  localparam int K_PERR = 3;
  localparam int K_OVR  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1, rx = 1'b1;
  logic en_a = 0, en_b = 0, en_c = 0, rdy_a = 0, rdy_b = 0, rdy_c = 0;
  logic [7:0] a_dout, b_dout, c_dout;
  logic a_valid, a_busy, a_done, a_ferr, a_perr, a_ovr;
  logic b_valid, b_busy, b_done, b_ferr, b_perr, b_ovr;
  logic c_valid, c_busy, c_done, c_ferr, c_perr, c_ovr;

  uart_rx_core u_a (
    .clk(clk), .reset(reset), .rx_en(en_a), .rx(rx), .data_out(a_dout),
    .rx_valid(a_valid), .rx_ready(rdy_a), .rx_busy(a_busy), .rx_done(a_done),
    .frame_err(a_ferr), .parity_err(a_perr), .rx_overrun(a_ovr));

  uart_rx_core #(.CLK_FREQ(3200000), .BAUD_RATE(100000), .OVERSAMPLE(16),
                 .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) u_b (
    .clk(clk), .reset(reset), .rx_en(en_b), .rx(rx), .data_out(b_dout),
    .rx_valid(b_valid), .rx_ready(rdy_b), .rx_busy(b_busy), .rx_done(b_done),
    .frame_err(b_ferr), .parity_err(b_perr), .rx_overrun(b_ovr));

  uart_rx_core #(.CLK_FREQ(3200000), .BAUD_RATE(100000), .OVERSAMPLE(16),
                 .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) u_c (
    .clk(clk), .reset(reset), .rx_en(en_c), .rx(rx), .data_out(c_dout),
    .rx_valid(c_valid), .rx_ready(rdy_c), .rx_busy(c_busy), .rx_done(c_done),
    .frame_err(c_ferr), .parity_err(c_perr), .rx_overrun(c_ovr));

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event word: {dut[1:0], kind[2:0], 1'b0, data[7:0]}
  typedef logic [13:0] ev_t;
  ev_t got_q[$];
  ev_t exp_q[$];
  int  rd_idx = 0;
  int unsigned done_cyc_a = 0;
  int unsigned frame_c0 = 0;
  int n_checks = 0, n_fail = 0;

  function automatic ev_t mk_ev(input int dut, input int kind, input logic [7:0] d);
    logic [1:0] du = dut[1:0];
    logic [2:0] ki = kind[2:0];
    return {du, ki, 1'b0, d};
  endfunction

  always @(negedge clk) begin
    if (a_done) begin got_q.push_back(mk_ev(0, K_DONE, a_dout)); done_cyc_a = cyc; end
    if (a_ferr) got_q.push_back(mk_ev(0, K_FERR, 8'h00));
    if (a_perr) got_q.push_back(mk_ev(0, K_PERR, 8'h00));
    if (a_ovr)  got_q.push_back(mk_ev(0, K_OVR, 8'h00));
    if (b_done) got_q.push_back(mk_ev(1, K_DONE, b_dout));
    if (b_ferr) got_q.push_back(mk_ev(1, K_FERR, 8'h00));
    if (b_perr) got_q.push_back(mk_ev(1, K_PERR, 8'h00));
    if (b_ovr)  got_q.push_back(mk_ev(1, K_OVR, 8'h00));
    if (c_done) got_q.push_back(mk_ev(2, K_DONE, c_dout));
    if (c_ferr) got_q.push_back(mk_ev(2, K_FERR, 8'h00));
    if (c_perr) got_q.push_back(mk_ev(2, K_PERR, 8'h00));
    if (c_ovr)  got_q.push_back(mk_ev(2, K_OVR, 8'h00));
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached at cycle %0d, required earlier finish", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Compare every event seen since the last call against the expected list.
  task automatic settle_events(input string tag);
    int avail;
    avail = got_q.size() - rd_idx;
    check({tag, " event count"}, 32'(avail), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < avail; i++)
      check($sformatf("%s event%0d", tag, i), 32'(got_q[rd_idx + i]), 32'(exp_q[i]));
    rd_idx = got_q.size();
    exp_q.delete();
  endtask

  function automatic int bedge(input int k, input int bitclk, input int pm);
    return (k * bitclk * pm + 500) / 1000;
  endfunction

  // Drive start, nb data bits LSB first, optional parity, stop; pm = bit length in permille.
  task automatic send_frame(input logic [8:0] d, input int nb, input bit has_par,
                            input logic pbit, input logic stop, input int bitclk, input int pm);
    logic bits[$];
    int len;
    bits.push_back(1'b0);
    for (int i = 0; i < nb; i++) bits.push_back(d[i]);
    if (has_par) bits.push_back(pbit);
    bits.push_back(stop);
    @(posedge clk);
    #1;
    frame_c0 = cyc;
    for (int k = 0; k < bits.size(); k++) begin
      len = bedge(k + 1, bitclk, pm) - bedge(k, bitclk, pm);
      rx = bits[k];
      repeat (len) @(posedge clk);
      #1;
    end
  endtask

  function automatic logic get_valid(input int dut);
    return (dut == 1) ? b_valid : c_valid;
  endfunction
  function automatic logic [7:0] get_dout(input int dut);
    return (dut == 1) ? b_dout : c_dout;
  endfunction

  typedef struct {
    int dut; logic [7:0] d; logic pbit; logic stop; int pm; logic rdy; int gap;
    int ekind; logic [7:0] edata; logic chk; logic evalid; logic [7:0] edout;
  } vec_t;
  vec_t tbl[14];

  int unsigned lat;
  bit          vm[3];
  logic [7:0]  dm[3];
  int   r_dut, r_pm, r_gap;
  logic [7:0] r_d;
  logic r_stop, r_pok, r_rdy;

  initial begin
    tbl[0]  = '{1, 8'h55, 1'b0, 1'b1, 1000, 1'b1, 0, K_DONE, 8'h55, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1, 8'hF0, 1'b0, 1'b1, 1000, 1'b1, 0, K_DONE, 8'hF0, 1'b0, 1'b0, 8'h00};
    tbl[2]  = '{1, 8'h0F, 1'b0, 1'b1, 1000, 1'b1, 0, K_DONE, 8'h0F, 1'b0, 1'b0, 8'h00};
    tbl[3]  = '{1, 8'h55, 1'b0, 1'b1,  970, 1'b1, 0, K_DONE, 8'h55, 1'b0, 1'b0, 8'h00};
    tbl[4]  = '{1, 8'hF0, 1'b0, 1'b1,  970, 1'b1, 0, K_DONE, 8'hF0, 1'b0, 1'b0, 8'h00};
    tbl[5]  = '{1, 8'h0F, 1'b0, 1'b1,  970, 1'b1, 0, K_DONE, 8'h0F, 1'b0, 1'b0, 8'h00};
    tbl[6]  = '{1, 8'h55, 1'b0, 1'b1, 1030, 1'b1, 0, K_DONE, 8'h55, 1'b0, 1'b0, 8'h00};
    tbl[7]  = '{1, 8'hF0, 1'b0, 1'b1, 1030, 1'b1, 0, K_DONE, 8'hF0, 1'b0, 1'b0, 8'h00};
    tbl[8]  = '{1, 8'h0F, 1'b0, 1'b1, 1030, 1'b1, 2, K_DONE, 8'h0F, 1'b1, 1'b0, 8'h00};
    tbl[9]  = '{2, 8'h07, 1'b1, 1'b1, 1000, 1'b1, 2, K_DONE, 8'h07, 1'b1, 1'b0, 8'h00};
    tbl[10] = '{2, 8'h07, 1'b0, 1'b1, 1000, 1'b1, 2, K_PERR, 8'h00, 1'b1, 1'b0, 8'h00};
    tbl[11] = '{2, 8'hA5, 1'b0, 1'b1, 1030, 1'b1, 2, K_DONE, 8'hA5, 1'b1, 1'b0, 8'h00};
    tbl[12] = '{1, 8'h11, 1'b0, 1'b1, 1000, 1'b0, 2, K_DONE, 8'h11, 1'b1, 1'b1, 8'h11};
    tbl[13] = '{1, 8'h22, 1'b0, 1'b1, 1000, 1'b0, 2, K_OVR,  8'h00, 1'b1, 1'b1, 8'h11};

    // Reset state
    wait_clk(4);
    reset = 1'b0;
    wait_clk(2);
    check("reset a_valid", 32'(a_valid), 0);
    check("reset a_busy", 32'(a_busy), 0);
    check("reset a_dout", 32'(a_dout), 0);
    check("reset b_valid", 32'(b_valid), 0);
    check("reset b_dout", 32'(b_dout), 0);
    settle_events("reset");

    // Default-rate frame 0xAA held with rx_ready low
    en_a = 1'b1;
    exp_q.push_back(mk_ev(0, K_DONE, 8'hAA));
    fork
      send_frame(9'h0AA, 8, 1'b0, 1'b0, 1'b1, BIT_A, 1000);
      begin
        wait_clk(5 * BIT_A);
        check("a busy mid-frame", 32'(a_busy), 1);
      end
    join
    wait_clk(BIT_A);
    settle_events("frame AA");
    lat = done_cyc_a - frame_c0;
    check("a done latency in [9.5,10) bits", 32'(lat >= 8208 && lat < 8640), 1);
    check("a valid after AA", 32'(a_valid), 1);
    check("a dout after AA", 32'(a_dout), 32'h AA);

    // 200-clk low glitch on idle line
    rx = 1'b0;
    wait_clk(100);
    check("glitch busy in start", 32'(a_busy), 1);
    wait_clk(100);
    rx = 1'b1;
    wait_clk(400);
    check("glitch busy dropped", 32'(a_busy), 0);
    settle_events("glitch");
    check("glitch valid kept", 32'(a_valid), 1);
    check("glitch dout kept", 32'(a_dout), 32'hAA);
    rdy_a = 1'b1;
    wait_clk(2);
    check("a valid after accept", 32'(a_valid), 0);
    rdy_a = 1'b0;
    en_a = 1'b0;

    // Vector table on the fast instances
    for (int i = 0; i < 14; i++) begin
      en_b = (tbl[i].dut == 1);
      en_c = (tbl[i].dut == 2);
      if (tbl[i].dut == 1) rdy_b = tbl[i].rdy; else rdy_c = tbl[i].rdy;
      if (tbl[i].ekind != 0) exp_q.push_back(mk_ev(tbl[i].dut, tbl[i].ekind, tbl[i].edata));
      send_frame({1'b0, tbl[i].d}, 8, tbl[i].dut == 2, tbl[i].pbit, tbl[i].stop, BIT_F, tbl[i].pm);
      rx = 1'b1;
      if (tbl[i].gap > 0) begin
        wait_clk(tbl[i].gap * BIT_F);
        settle_events($sformatf("vec%0d", i));
        if (tbl[i].chk) begin
          check($sformatf("vec%0d valid", i), 32'(get_valid(tbl[i].dut)), 32'(tbl[i].evalid));
          if (tbl[i].evalid)
            check($sformatf("vec%0d dout", i), 32'(get_dout(tbl[i].dut)), 32'(tbl[i].edout));
        end
      end
    end

    // rx_en dropped mid-frame while 0x11 is held
    fork
      send_frame(9'h033, 8, 1'b0, 1'b0, 1'b1, BIT_F, 1000);
      begin
        wait_clk(4 * BIT_F);
        check("en-drop busy before", 32'(b_busy), 1);
        en_b = 1'b0;
        wait_clk(1);
        check("en-drop busy after", 32'(b_busy), 0);
      end
    join
    wait_clk(BIT_F);
    settle_events("en-drop");
    check("en-drop valid kept", 32'(b_valid), 1);
    check("en-drop dout kept", 32'(b_dout), 32'h11);
    en_b = 1'b1;

    // Stop bit low then line held low: one frame error, no repeats
    rdy_b = 1'b1;
    wait_clk(2);
    exp_q.push_back(mk_ev(1, K_FERR, 8'h00));
    send_frame(9'h03C, 8, 1'b0, 1'b0, 1'b0, BIT_F, 1000);
    wait_clk(2 * BIT_F);
    check("break busy low", 32'(b_busy), 0);
    wait_clk(BIT_F);
    rx = 1'b1;
    wait_clk(BIT_F);
    settle_events("break");
    exp_q.push_back(mk_ev(1, K_DONE, 8'h81));
    send_frame(9'h081, 8, 1'b0, 1'b0, 1'b1, BIT_F, 1000);
    wait_clk(2 * BIT_F);
    settle_events("after break");

    // Randomized frames against the behavioural model
    vm[1] = 1'b0; vm[2] = 1'b0; dm[1] = 8'h00; dm[2] = 8'h00;
    for (int n = 0; n < 40; n++) begin
      r_dut  = $urandom_range(1, 2);
      r_d    = 8'($urandom);
      r_stop = ($urandom_range(0, 9) != 0);
      r_pok  = ($urandom_range(0, 4) != 0);
      r_rdy  = 1'($urandom_range(0, 1));
      r_gap  = $urandom_range(1, 2);
      case ($urandom_range(0, 2))
        0: r_pm = 970;
        1: r_pm = 1000;
        default: r_pm = 1030;
      endcase
      en_b = (r_dut == 1);
      en_c = (r_dut == 2);
      if (r_dut == 1) rdy_b = r_rdy; else rdy_c = r_rdy;
      if (r_rdy) vm[r_dut] = 1'b0;
      if (!r_stop) exp_q.push_back(mk_ev(r_dut, K_FERR, 8'h00));
      else if (r_dut == 2 && !r_pok) exp_q.push_back(mk_ev(r_dut, K_PERR, 8'h00));
      else if (r_rdy || !vm[r_dut]) begin
        exp_q.push_back(mk_ev(r_dut, K_DONE, r_d));
        vm[r_dut] = !r_rdy;
        dm[r_dut] = r_d;
      end else exp_q.push_back(mk_ev(r_dut, K_OVR, 8'h00));
      send_frame({1'b0, r_d}, 8, r_dut == 2, r_pok ? ^r_d : ~(^r_d), r_stop, BIT_F, r_pm);
      rx = 1'b1;
      wait_clk(r_gap * BIT_F);
      settle_events($sformatf("rand%0d", n));
      check($sformatf("rand%0d valid", n), 32'(get_valid(r_dut)), 32'(vm[r_dut]));
      if (vm[r_dut]) check($sformatf("rand%0d dout", n), 32'(get_dout(r_dut)), 32'(dm[r_dut]));
    end

    // Reset in the middle of a frame with a byte held
    en_b = 1'b1; en_c = 1'b0;
    rdy_b = 1'b1;
    wait_clk(2);
    rdy_b = 1'b0;
    exp_q.push_back(mk_ev(1, K_DONE, 8'h5A));
    send_frame(9'h05A, 8, 1'b0, 1'b0, 1'b1, BIT_F, 1000);
    wait_clk(2 * BIT_F);
    settle_events("pre-reset");
    fork
      send_frame(9'h044, 8, 1'b0, 1'b0, 1'b1, BIT_F, 1000);
      begin
        wait_clk(4 * BIT_F);
        check("mid-reset busy before", 32'(b_busy), 1);
        reset = 1'b1;
        en_b = 1'b0;
        wait_clk(1);
        check("mid-reset busy", 32'(b_busy), 0);
        check("mid-reset valid", 32'(b_valid), 0);
        check("mid-reset dout", 32'(b_dout), 0);
        reset = 1'b0;
      end
    join
    wait_clk(2 * BIT_F);
    settle_events("mid-reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- Standalone UART receiver: the serial-in end of the link driven by the team's transmitter.
- Samples the asynchronous `rx` line with an OVERSAMPLE-times baud tick and a 3-sample majority vote.
- Checks start, optional parity and stop bits.
- Presents each good byte through a one-entry valid/ready holding register with error pulses. Sits between the pad and any consumer: FIFO, register bank, or loopback checker against `uart_top`.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD_RATE, 115200, line bit rate.
- OVERSAMPLE, 16, ticks per bit. Must be ≥ 8.
- DATA_BITS, 8, payload bits per frame (5..9).
- PARITY_EN, 0, 1 = one parity bit follows the data bits.
- PARITY_ODD, 0, 1 = odd parity, 0 = even. Ignored when PARITY_EN = 0.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- rx_en  in  1  receiver enable.
- rx  in  1  asynchronous serial input, idle high.
- data_out  out  DATA_BITS  received byte, LSB = first bit on the line.
- rx_valid  out  1  data_out holds an unread byte.
- rx_ready  in  1  consumer accepts data_out when rx_valid && rx_ready.
- rx_busy  out  1  frame reception in progress.
- rx_done  out  1  one-cycle pulse when a good frame is loaded.
- frame_err  out  1  one-cycle pulse when the stop bit is sampled low.
- parity_err  out  1  one-cycle pulse when parity mismatches.
- rx_overrun  out  1  one-cycle pulse when a good frame is dropped because the holding register is full.

Behaviour:
- **Reset.**
  - Synchronizer flops = 1, state = IDLE, tick and sample counters = 0.
  - data_out = 0; rx_valid, rx_busy, rx_done, frame_err, parity_err, rx_overrun = 0.
- **Synchronizer.** `rx` passes through 2 flops (rx_s). All decisions use rx_s, which adds 2 clk of latency.
- **Tick generator.**
  - DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), integer truncation. Defaults give 54.
  - Free-running counter 0..DIV-1; tick asserts on the cycle the count equals DIV-1.
  - Bit period = DIV*OVERSAMPLE clk (864 at defaults).
- **Sample counter** `s`, 0..OVERSAMPLE-1, increments per tick inside a bit:
  - rx_s is captured at s = M-1, M, M+1, where M = OVERSAMPLE/2.
  - The bit value is the majority of the three captures, decided at s = M+1.
  - The bit ends at s = OVERSAMPLE-1.
- **States:** IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: on a tick with rx_en = 1 and rx_s = 0 → START, with s = 0.
  - START: if the majority = 1, it is a glitch → IDLE with no pulses. Otherwise, at end of bit → DATA, bit index 0.
  - DATA: shift the majority in LSB-first at end of bit. After DATA_BITS bits → PARITY if PARITY_EN, else STOP.
  - PARITY: the majority is compared against the XOR of the data (inverted when PARITY_ODD); a mismatch result is stored. At end of bit → STOP.
  - STOP: decided at s = M+1, then exit immediately (half-bit early, to allow resync).
    - Majority 1 and parity OK → deliver, → IDLE.
    - Majority 1 and parity mismatch → parity_err pulse, no delivery, → IDLE.
    - Majority 0 → frame_err pulse, no delivery, → BREAK.
  - BREAK: on a tick with rx_s = 1 → IDLE. Line held low never produces repeated frames.
- **Delivery**, on the clk following the stop decision:
  - If rx_valid = 0, or the consumer accepts (rx_valid && rx_ready) in that same cycle: data_out ← shift register, rx_valid = 1, rx_done pulse.
  - Otherwise: rx_overrun pulse; the old data_out and rx_valid are retained and the new byte is discarded.
- **Handshake.**
  - rx_valid falls on the clk after rx_valid && rx_ready, unless a simultaneous delivery reloads it.
  - data_out is stable while rx_valid = 1.
- **rx_busy** = 1 in START, DATA, PARITY, STOP. It is 0 in IDLE and BREAK.
- **rx_en = 0.**
  - In any state, the next clk forces IDLE with no pulses; any partial frame is dropped.
  - The holding register and rx_valid are unaffected.
- **Mid-frame reset** returns everything to reset values on the next clk edge.
- **Pulse exclusivity.** At most one of rx_done, frame_err, parity_err, rx_overrun asserts per frame.

Test Plan:
1. Defaults. Drive 0xAA (bit period 864 clk, ideal timing), rx_ready = 0 → rx_done pulse, rx_valid = 1, data_out = 0xAA, about 9.5 bit periods + 3 clk after the start edge; rx_busy high throughout the frame.
2. Back-to-back 0x55, 0xF0, 0x0F with rx_ready = 1 each cycle → three rx_done pulses with data_out 0x55, 0xF0, 0x0F; no rx_overrun. Repeat with baud timing skewed ±3% → same result.
3. Low glitch of 200 clk on an idle line → no state change beyond START, rx_busy drops by mid-bit, no pulses, rx_valid unchanged.
4. Frame 0x3C with the stop bit driven low, then the line held low for 3 bit periods → one frame_err pulse, no rx_done, rx_busy = 0 while the line stays low. Release high, then send 0x81 → data_out = 0x81.
5. PARITY_EN = 1, PARITY_ODD = 0. Send 0x07 with parity bit 1 → rx_done, data_out = 0x07. Send 0x07 with parity bit 0 → parity_err pulse, no delivery.
6. rx_ready = 0, send 0x11 then 0x22 → data_out stays 0x11, rx_overrun pulses once. Drop rx_en at mid-frame of a third byte → rx_busy falls next clk, no pulses. Assert reset mid-frame → all outputs 0.
